uart_tx_mmio: RTL and testbench

- Memory-mapped UART transmitter on the CPU data-memory bus, downstream of the store path (StoreSel/storegen → MemRW).
- CPU stores bytes to TXDATA; bytes are buffered in a small FIFO and serialised 8N1, LSB first, on O_tx.
- STATUS and CTRL registers are readable on the same bus, so firmware can poll or take an interrupt.

---
 rtl/uart_pkg.sv | 51 +++++
 rtl/uart_fifo.sv | 67 ++++++
 rtl/uart_tx_mmio.sv | 241 ++++++++++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the memory-mapped UART transmitter:
//   register word offsets (decoded on address bits [3:2]), STATUS/CTRL bit
//   positions, the CTRL reset value and the transmit FSM state encoding.
//
//   Optional build macro: UART_TX_PARITY_EN
//     defined   -> PARITY state exists (3-bit state encoding), STATUS bit11 = 1
//     undefined -> 8N1 framing only (2-bit state encoding), STATUS bit11 = 0
// -----------------------------------------------------------------------------
package uart_pkg;

    // Register word offsets, compared against I_addr[3:2]
    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_RSVD   = 2'd3;

    // STATUS bit positions
    localparam int ST_FULL      = 0;
    localparam int ST_EMPTY     = 1;
    localparam int ST_BUSY      = 2;
    localparam int ST_OVF       = 3;
    localparam int ST_COUNT_LSB = 4;
    localparam int ST_COUNT_W   = 7;
    localparam int ST_PARITY    = 11;

    // CTRL bit positions
    localparam int CTRL_EN     = 0;
    localparam int CTRL_IRQ_EN = 1;

`ifdef UART_TX_PARITY_EN
    localparam logic PARITY_PRESENT = 1'b1;
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } tx_state_t;
`else
    localparam logic PARITY_PRESENT = 1'b0;
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_t;
`endif

endpackage

// File: rtl/uart_fifo.sv
// -----------------------------------------------------------------------------
// uart_fifo
//   Synchronous FIFO, WIDTH bits x DEPTH entries (DEPTH a power of 2).
//   Pointers carry one extra wrap bit so FULL/EMPTY come from comparing the
//   MSB and the index bits. The head entry is presented combinationally.
//
//   Ports:
//     I_clk, I_rst   clock, asynchronous active-low reset
//     I_push, I_din  write one entry (ignored when full unless popping too)
//     I_pop          remove the head entry (ignored when empty)
//     O_dout         current head entry
//     O_full/O_empty occupancy flags
//     O_count        number of stored entries (0..DEPTH)
// -----------------------------------------------------------------------------
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     I_clk,
    input  logic                     I_rst,
    input  logic                     I_push,
    input  logic                     I_pop,
    input  logic [WIDTH-1:0]         I_din,
    output logic [WIDTH-1:0]         O_dout,
    output logic                     O_full,
    output logic                     O_empty,
    output logic [$clog2(DEPTH):0]   O_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign O_empty = (r_wr_ptr == r_rd_ptr);
    assign O_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign O_count = r_wr_ptr - r_rd_ptr;
    assign O_dout  = r_mem[r_rd_ptr[AW-1:0]];

    // A push into a full FIFO is legal only when the head leaves this cycle.
    assign w_do_push = I_push && (!O_full || I_pop);
    assign w_do_pop  = I_pop && !O_empty;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge I_clk or negedge I_rst) begin
        if (!I_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    // NOTE: storage is not reset; entries are only visible between the
    // pointers, so clearing them would cost logic without changing behaviour.
    always_ff @(posedge I_clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= I_din;
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// -----------------------------------------------------------------------------
// uart_tx_mmio
//   Memory-mapped UART transmitter on the CPU data bus. Stores to TXDATA are
//   queued in a FIFO and serialised LSB first on O_tx (start, 8 data, stop).
//
//   Register window (16 bytes at BASE_ADDR, decoded on I_addr[3:2]):
//     0x0 TXDATA  WO  push I_wdata[7:0]; dropped with sticky OVF when full
//     0x4 STATUS  RO  [0]FULL [1]EMPTY [2]BUSY [3]OVF(W1C) [10:4]COUNT [11]PARITY
//     0x8 CTRL    RW  [0]EN [1]IRQ_EN, resets to 0x1
//     0xC reserved, reads 0
//
//   Ports:
//     I_clk, I_rst          clock, asynchronous active-low reset
//     I_addr, I_wdata       bus address / store data
//     I_we, I_re            write strobe / read qualifier
//     O_rdata               combinational read data (0 when not reading us)
//     O_tx                  serial line, idle high
//     O_irq                 registered level interrupt: IRQ_EN & EMPTY & !BUSY
//
//   Optional build macro: UART_TX_PARITY_EN adds an even parity bit before
//   the stop bit (11-bit frame) and sets STATUS bit11.
// -----------------------------------------------------------------------------
module uart_tx_mmio
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0001_0000,
    parameter int          CLKS_PER_BIT = 868,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        I_clk,
    input  logic        I_rst,
    input  logic [31:0] I_addr,
    input  logic [31:0] I_wdata,
    input  logic        I_we,
    input  logic        I_re,
    output logic [31:0] O_rdata,
    output logic        O_tx,
    output logic        O_irq
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BAUD_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] BAUD_ONE    = CNT_W'(1);

    // Bus decode
    logic w_sel;
    logic w_wr_txdata;
    logic w_wr_status;
    logic w_wr_ctrl;

    assign w_sel       = (I_addr[31:4] == BASE_ADDR[31:4]);
    assign w_wr_txdata = w_sel && I_we && (I_addr[3:2] == REG_TXDATA);
    assign w_wr_status = w_sel && I_we && (I_addr[3:2] == REG_STATUS);
    assign w_wr_ctrl   = w_sel && I_we && (I_addr[3:2] == REG_CTRL);

    // Control / status registers and FSM state
    logic             r_en;
    logic             r_irq_en;
    logic             r_ovf;
    logic             r_irq;
    logic             r_tx;
    tx_state_t        r_state;
    logic [7:0]       r_shift;
    logic [CNT_W-1:0] r_baud;
    logic [2:0]       r_bit_idx;
`ifdef UART_TX_PARITY_EN
    logic             r_parity;
`endif

    // FIFO interface
    logic        w_fifo_full;
    logic        w_fifo_empty;
    logic [7:0]  w_fifo_dout;
    logic [AW:0] w_fifo_count;
    logic        w_pop;
    logic        w_push;
    logic        w_drop;
    logic        w_busy;

    assign w_busy = (r_state != S_IDLE);
    assign w_pop  = (r_state == S_IDLE) && r_en && !w_fifo_empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO then
    // succeeds and does not count as an overflow.
    assign w_push = w_wr_txdata && (!w_fifo_full || w_pop);
    assign w_drop = w_wr_txdata && w_fifo_full && !w_pop;

    uart_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .I_clk   (I_clk),
        .I_rst   (I_rst),
        .I_push  (w_push),
        .I_pop   (w_pop),
        .I_din   (I_wdata[7:0]),
        .O_dout  (w_fifo_dout),
        .O_full  (w_fifo_full),
        .O_empty (w_fifo_empty),
        .O_count (w_fifo_count)
    );

    // CTRL, sticky OVF and the registered interrupt
    always_ff @(posedge I_clk or negedge I_rst) begin
        if (!I_rst) begin
            r_en     <= 1'b1;
            r_irq_en <= 1'b0;
            r_ovf    <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_en     <= I_wdata[CTRL_EN];
                r_irq_en <= I_wdata[CTRL_IRQ_EN];
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (w_wr_status && I_wdata[ST_OVF]) begin
                r_ovf <= 1'b0;
            end
            r_irq <= r_irq_en && w_fifo_empty && !w_busy;
        end
    end

    // Transmit FSM. O_tx is registered and set alongside each state change so
    // the line level always matches the state being entered.
    always_ff @(posedge I_clk or negedge I_rst) begin
        if (!I_rst) begin
            r_state   <= S_IDLE;
            r_tx      <= 1'b1;
            r_shift   <= '0;
            r_baud    <= '0;
            r_bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        r_shift <= w_fifo_dout;
`ifdef UART_TX_PARITY_EN
                        r_parity <= ^w_fifo_dout;
`endif
                        r_baud  <= BAUD_RELOAD;
                        r_state <= S_START;
                        r_tx    <= 1'b0;
                    end
                end
                S_START: begin
                    if (r_baud == '0) begin
                        r_baud    <= BAUD_RELOAD;
                        r_bit_idx <= '0;
                        r_state   <= S_DATA;
                        r_tx      <= r_shift[0];
                    end else begin
                        r_baud <= r_baud - BAUD_ONE;
                    end
                end
                S_DATA: begin
                    if (r_baud == '0) begin
                        r_baud <= BAUD_RELOAD;
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            r_state <= S_PARITY;
                            r_tx    <= r_parity;
`else
                            r_state <= S_STOP;
                            r_tx    <= 1'b1;
`endif
                        end else begin
                            r_shift   <= r_shift >> 1;
                            r_tx      <= r_shift[1];
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_baud <= r_baud - BAUD_ONE;
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (r_baud == '0) begin
                        r_baud  <= BAUD_RELOAD;
                        r_state <= S_STOP;
                        r_tx    <= 1'b1;
                    end else begin
                        r_baud <= r_baud - BAUD_ONE;
                    end
                end
`endif
                S_STOP: begin
                    // Counter is left at 0; IDLE reloads it on the next pop.
                    if (r_baud == '0) begin
                        r_state <= S_IDLE;
                        r_tx    <= 1'b1;
                    end else begin
                        r_baud <= r_baud - BAUD_ONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    // Read path
    logic [31:0] w_status;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_status                                 = '0;
        w_status[ST_FULL]                        = w_fifo_full;
        w_status[ST_EMPTY]                       = w_fifo_empty;
        w_status[ST_BUSY]                        = w_busy;
        w_status[ST_OVF]                         = r_ovf;
        w_status[ST_COUNT_LSB +: ST_COUNT_W]     = ST_COUNT_W'(w_fifo_count);
        w_status[ST_PARITY]                      = PARITY_PRESENT;
    end

    always_comb begin
        O_rdata = '0;
        if (w_sel && I_re) begin
            case (I_addr[3:2])
                REG_STATUS: O_rdata = w_status;
                REG_CTRL:   O_rdata = {30'd0, r_irq_en, r_en};
                default:    O_rdata = '0;
            endcase
        end
    end

    assign O_tx  = r_tx;
    assign O_irq = r_irq;

    // Byte-lane bits and upper store data carry no meaning for this block.
    logic w_unused_bits;
    assign w_unused_bits = &{1'b0, I_addr[1:0], I_wdata[31:8]};

endmodule

// File: tb/tb_uart_tx_mmio.sv
module tb_uart_tx_mmio;

    localparam logic [31:0] BASE   = 32'h0001_0000;
    localparam int          CPB    = 4;
    localparam int          DEPTH  = 8;
    localparam int          FRAME  = 10 * CPB;
    localparam logic [31:0] A_TX   = BASE + 32'h0;
    localparam logic [31:0] A_ST   = BASE + 32'h4;
    localparam logic [31:0] A_CTRL = BASE + 32'h8;
    localparam logic [31:0] A_RSV  = BASE + 32'hC;

    logic        I_clk = 1'b0;
    logic        I_rst = 1'b0;
    logic [31:0] I_addr = '0;
    logic [31:0] I_wdata = '0;
    logic        I_we = 1'b0;
    logic        I_re = 1'b0;
    logic [31:0] O_rdata;
    logic        O_tx;
    logic        O_irq;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    int         start_q[$];

    uart_tx_mmio #(
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .I_clk   (I_clk),
        .I_rst   (I_rst),
        .I_addr  (I_addr),
        .I_wdata (I_wdata),
        .I_we    (I_we),
        .I_re    (I_re),
        .O_rdata (O_rdata),
        .O_tx    (O_tx),
        .O_irq   (O_irq)
    );

    always #5 I_clk = ~I_clk;
    always @(posedge I_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Expected STATUS word built from the register description.
    function automatic logic [31:0] status_exp(input int cnt, input bit ovf, input bit busy);
        return (cnt << 4) | (32'(ovf) << 3) | (32'(busy) << 2) |
               (32'(cnt == 0) << 1) | 32'(cnt == DEPTH);
    endfunction

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge I_clk);
        I_addr  = a;
        I_wdata = d;
        I_we    = 1'b1;
        @(posedge I_clk);
        #1;
        I_we = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge I_clk);
        I_addr = a;
        I_re   = 1'b1;
        #1;
        d    = O_rdata;
        I_re = 1'b0;
    endtask

    // Serial receiver: samples O_tx once per cycle, captures a whole frame
    // after the first low sample and derives the byte from bit centres.
    bit             mon_active = 1'b0;
    int             mon_idx = 0;
    logic [FRAME-1:0] mon_samp;
    logic [FRAME-1:0] mon_shape;
    logic [7:0]     mon_byte;

    initial begin
        forever begin
            @(negedge I_clk);
            if (!I_rst) begin
                mon_active = 1'b0;
            end else begin
                if (!mon_active && O_tx == 1'b0) begin
                    mon_active = 1'b1;
                    mon_idx    = 0;
                    start_q.push_back(cyc);
                end
                if (mon_active) begin
                    mon_samp[mon_idx] = O_tx;
                    mon_idx++;
                    if (mon_idx == FRAME) begin
                        for (int i = 0; i < 8; i++) mon_byte[i] = mon_samp[CPB * (i + 1) + CPB / 2];
                        for (int i = 0; i < FRAME; i++) begin
                            int b;
                            b = i / CPB;
                            mon_shape[i] = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : mon_byte[b - 1];
                        end
                        check("frame_shape", 64'(mon_samp), 64'(mon_shape));
                        rx_q.push_back(mon_byte);
                        mon_active = 1'b0;
                    end
                end
            end
        end
    end

    task automatic wait_rx(input int n);
        int k;
        k = 0;
        while (rx_q.size() < n && k < n * (FRAME + 1) + 40) begin
            @(negedge I_clk);
            k++;
        end
        check("rx_frames_arrived", 64'(rx_q.size() >= n), 64'd1);
        repeat (3) @(negedge I_clk);
    endtask

    task automatic compare_rx(input string tag);
        check({tag, "_count"}, 64'(rx_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            check({tag, "_byte"}, 64'(rx_q[i]), 64'(exp_q[i]));
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic check_gaps(input string tag);
        for (int i = 1; i < start_q.size(); i++)
            check({tag, "_start_gap"}, 64'(start_q[i] - start_q[i - 1]), 64'(FRAME + 1));
    endtask

    // Waits for the line to drop; returns whether it did within the bound.
    task automatic wait_start(output bit found, output int irq_high);
        int lat;
        found    = 1'b0;
        irq_high = 0;
        lat      = 0;
        while (!found && lat < 4) begin
            @(negedge I_clk);
            #1;
            if (O_irq) irq_high++;
            if (O_tx == 1'b0) found = 1'b1;
            else lat++;
        end
        check("start_latency", 64'(found), 64'd1);
    endtask

    logic [31:0] rd;
    logic [7:0]  b8;
    bit          found;
    int          bad;
    int          cnt;
    bit          ovf;
    int          n;

    initial begin
        // ---- reset / idle ----
        #20;
        I_rst = 1'b1;
        @(negedge I_clk);
        check("reset_tx", 64'(O_tx), 64'd1);
        check("reset_irq", 64'(O_irq), 64'd0);
        bus_read(A_ST, rd);   check("reset_status", 64'(rd), 64'h002);
        bus_read(A_CTRL, rd); check("reset_ctrl", 64'(rd), 64'h1);
        bus_read(A_TX, rd);   check("txdata_reads_0", 64'(rd), 64'h0);
        bus_read(A_RSV, rd);  check("reserved_reads_0", 64'(rd), 64'h0);
        bus_read(BASE + 32'h18, rd); check("unselected_reads_0", 64'(rd), 64'h0);

        // ---- single byte with BUSY tracking ----
        start_q.delete();
        exp_q.push_back(8'h55);
        bus_write(A_TX, 32'h55);
        I_addr = A_ST;
        I_re   = 1'b1;
        wait_start(found, bad);
        if (found) begin
            bad = (O_rdata[2] == 1'b1) ? 0 : 1;
            for (int k = 1; k < FRAME; k++) begin
                @(negedge I_clk);
                #1;
                if (O_rdata[2] !== 1'b1) bad++;
            end
            check("busy_whole_frame_bad_cycles", 64'(bad), 64'd0);
            @(negedge I_clk);
            #1;
            check("busy_clear_after_frame", 64'(O_rdata[2]), 64'd0);
        end
        I_re = 1'b0;
        wait_rx(1);
        compare_rx("single");

        // ---- overflow, W1C, ordered drain ----
        bus_write(A_CTRL, 32'h0);
        for (int i = 0; i < DEPTH + 1; i++) begin
            b8 = 8'($urandom);
            if (i < DEPTH) exp_q.push_back(b8);
            bus_write(A_TX, {24'($urandom), b8});
        end
        bus_read(A_ST, rd); check("ovf_status", 64'(rd), 64'(status_exp(DEPTH, 1, 0)));
        bus_write(A_ST, 32'hFFFF_FFF7);
        bus_read(A_ST, rd); check("status_ro_bits", 64'(rd), 64'(status_exp(DEPTH, 1, 0)));
        bus_write(A_ST, 32'h8);
        bus_read(A_ST, rd); check("ovf_w1c", 64'(rd), 64'(status_exp(DEPTH, 0, 0)));
        start_q.delete();
        bus_write(A_CTRL, 32'h1);
        wait_rx(DEPTH);
        compare_rx("ovf_drain");
        check_gaps("ovf_drain");

        // ---- push into a full FIFO on the pop cycle ----
        bus_write(A_CTRL, 32'h0);
        for (int i = 0; i < DEPTH; i++) begin
            b8 = 8'($urandom);
            exp_q.push_back(b8);
            bus_write(A_TX, 32'(b8));
        end
        bus_write(A_CTRL, 32'h1);
        bus_write(A_TX, 32'hA5);
        exp_q.push_back(8'hA5);
        bus_read(A_ST, rd); check("collision_status", 64'(rd), 64'(status_exp(DEPTH, 0, 1)));
        wait_rx(DEPTH + 1);
        compare_rx("collision");

        // ---- interrupt timing ----
        bus_write(A_CTRL, 32'h0);
        exp_q.push_back(8'h0F);
        bus_write(A_TX, 32'h0F);
        bus_write(A_CTRL, 32'h3);
        wait_start(found, bad);
        if (found) begin
            if (O_irq) bad++;
            for (int k = 1; k <= FRAME; k++) begin
                @(negedge I_clk);
                #1;
                if (O_irq !== 1'b0) bad++;
            end
            check("irq_low_during_frame", 64'(bad), 64'd0);
            @(negedge I_clk);
            #1;
            check("irq_rises_after_stop", 64'(O_irq), 64'd1);
        end
        b8 = 8'($urandom);
        exp_q.push_back(b8);
        bus_write(A_TX, 32'(b8));
        @(negedge I_clk);
        check("irq_still_high_store_cycle", 64'(O_irq), 64'd1);
        @(negedge I_clk);
        check("irq_drops_after_store", 64'(O_irq), 64'd0);
        wait_rx(2);
        compare_rx("irq");
        check("irq_back_after_drain", 64'(O_irq), 64'd1);
        bus_write(A_CTRL, 32'h1);

        // ---- randomized fill / drain rounds ----
        for (int r = 0; r < 5; r++) begin
            bus_write(A_CTRL, 32'h0);
            cnt = 0;
            ovf = 1'b0;
            n = $urandom_range(1, DEPTH + 3);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0)
                    bus_write(BASE + 32'h20, $urandom);
                if ($urandom_range(0, 3) == 0)
                    bus_write(A_RSV, $urandom);
                b8 = 8'($urandom);
                if (cnt < DEPTH) begin
                    exp_q.push_back(b8);
                    cnt++;
                end else begin
                    ovf = 1'b1;
                end
                bus_write(A_TX, {24'($urandom), b8});
            end
            bus_read(A_ST, rd); check("rand_status", 64'(rd), 64'(status_exp(cnt, ovf, 0)));
            if (ovf) begin
                bus_write(A_ST, 32'h8);
                bus_read(A_ST, rd); check("rand_ovf_clear", 64'(rd), 64'(status_exp(cnt, 0, 0)));
            end
            start_q.delete();
            bus_write(A_CTRL, 32'h1);
            wait_rx(cnt);
            compare_rx("rand");
            check_gaps("rand");
        end

        // ---- reset in the middle of a frame ----
        bus_write(A_CTRL, 32'h0);
        bus_write(A_TX, 32'($urandom_range(0, 255)));
        bus_write(A_TX, 32'($urandom_range(0, 255)));
        bus_write(A_CTRL, 32'h1);
        wait_start(found, bad);
        repeat (17) @(negedge I_clk);
        #1;
        I_rst = 1'b0;
        #1;
        check("midframe_reset_tx_high", 64'(O_tx), 64'd1);
        check("midframe_reset_irq_low", 64'(O_irq), 64'd0);
        repeat (2) @(negedge I_clk);
        I_rst = 1'b1;
        rx_q.delete();
        exp_q.delete();
        bus_read(A_ST, rd);   check("post_reset_status", 64'(rd), 64'h002);
        bus_read(A_CTRL, rd); check("post_reset_ctrl", 64'(rd), 64'h1);
        bad = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge I_clk);
            #1;
            if (O_tx !== 1'b1) bad++;
        end
        check("post_reset_line_idle", 64'(bad), 64'd0);
        check("post_reset_no_frames", 64'(rx_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
